// File: rtl/mon_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mon_tx_scheduler
// Purpose  : Arbitrates power-on reply, generic and audio frames onto the
//            single monitor-bound Sender, one frame per fixed-length slot.
// Revision : 1.0 - initial release
// ============================================================================
module mon_tx_scheduler #(
    parameter int          FRAME_CYCLES = 48,
    parameter logic [39:0] PWR_WORD     = 40'hC0_0000_0000,
    parameter logic [39:0] AUDIO_WORD   = 40'hC7_0000_0000
) (
    input  logic        mon_clk,
    input  logic        rst_n,
    input  logic        tx_enable,
    input  logic        pwr_req,
    input  logic        audio_req,
    input  logic        gen_valid,
    input  logic [39:0] gen_data,
    output logic        gen_ready,
    output logic [39:0] out_data,
    output logic        out_valid,
    output logic        busy,
    output logic [7:0]  audio_drop_cnt
);

    localparam logic [7:0] c_SLOT_LOAD = 8'(FRAME_CYCLES - 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_SLOT  = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_slot_cnt;
    logic        r_pwr_pend;
    logic        r_aud_pend;
    logic [1:0]  r_arm;

    logic        w_arb_point;
    logic        w_can_grant;
    logic        w_pwr_first;
    logic        w_grant_pwr;
    logic        w_grant_gen;
    logic        w_grant_aud;
    logic        w_grant_any;

    // The last slot cycle arbitrates like IDLE so back-to-back frames land
    // exactly FRAME_CYCLES apart instead of FRAME_CYCLES+1.
    assign w_arb_point = (r_state == ST_IDLE) ||
                         ((r_state == ST_SLOT) && (r_slot_cnt == 8'd0));
    assign w_can_grant = w_arb_point && tx_enable && r_arm[1];

    // A power pulse arriving this cycle holds off lower priorities so that a
    // simultaneous generic offer cannot overtake it.
    assign w_pwr_first = r_pwr_pend || pwr_req;
    assign w_grant_pwr = w_can_grant && r_pwr_pend;
    assign w_grant_gen = w_can_grant && !w_pwr_first && gen_valid;
    assign w_grant_aud = w_can_grant && !w_pwr_first && !gen_valid && r_aud_pend;
    assign w_grant_any = w_grant_pwr || w_grant_gen || w_grant_aud;

    // Two-stage arm keeps the first post-reset strobe >= 2 cycles after release.
    always_ff @(posedge mon_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arm <= 2'b00;
        end else begin
            r_arm <= {r_arm[0], 1'b1};
        end
    end

    always_ff @(posedge mon_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwr_pend     <= 1'b0;
            r_aud_pend     <= 1'b0;
            audio_drop_cnt <= 8'd0;
        end else begin
            r_pwr_pend <= (r_pwr_pend && !w_grant_pwr) || pwr_req;
            r_aud_pend <= (r_aud_pend && !w_grant_aud) || audio_req;
            if (audio_req && r_aud_pend && !w_grant_aud && (audio_drop_cnt != 8'hFF)) begin
                audio_drop_cnt <= audio_drop_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge mon_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_slot_cnt <= 8'd0;
            out_valid  <= 1'b0;
            gen_ready  <= 1'b0;
            out_data   <= 40'd0;
            busy       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            gen_ready <= 1'b0;
            case (r_state)
                ST_ISSUE: begin
                    r_slot_cnt <= c_SLOT_LOAD;
                    r_state    <= ST_SLOT;
                end
                ST_IDLE, ST_SLOT: begin
                    if (!w_arb_point) begin
                        r_slot_cnt <= r_slot_cnt - 8'd1;
                    end else if (w_grant_any) begin
                        r_state   <= ST_ISSUE;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        gen_ready <= w_grant_gen;
                        out_data  <= w_grant_pwr ? PWR_WORD :
                                     (w_grant_gen ? gen_data : AUDIO_WORD);
                    end else begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
